controller_reader: RTL and testbench

//  Serial game-controller front end. Polls an 8-button shift-register pad (latch/pulse/data)
//  and produces the parallel button vector {Start,C,B,A,Right,Left,Down,Up} that is consumed
//  by the UI and homescreen FSMs and by game logic. Also produces one-cycle press-edge flags
//  and a frame-valid strobe. Sits between the pad pins and the system logic, in the clk domain.

---
 rtl/controller_reader_if.sv | 31 +++
 rtl/controller_reader.sv | 153 +++++++++++++++
 tb/tb_controller_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/controller_reader_if.sv
// Pin and system-side bundle for the serial pad reader.
// The slave modport is the reader itself; the master modport is the pad/system side.
interface controller_reader_if;
    logic       en;
    logic       ctrl_data;
    logic       ctrl_latch;
    logic       ctrl_pulse;
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic       valid;

    modport master (
        output en,
        output ctrl_data,
        input  ctrl_latch,
        input  ctrl_pulse,
        input  buttons,
        input  pressed,
        input  valid
    );

    modport slave (
        input  en,
        input  ctrl_data,
        output ctrl_latch,
        output ctrl_pulse,
        output buttons,
        output pressed,
        output valid
    );
endinterface

// File: rtl/controller_reader.sv
// Serial game-controller front end: polls an 8-button latch/pulse/data pad and
// presents a registered button vector, press-edge flags and a frame strobe.
module controller_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    controller_reader_if.slave bus
);
    localparam int CNT_W  = $clog2(2 * CLK_DIV) + 1;
    localparam int POLL_W = $clog2(POLL_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  HALF      = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        buttons_q, buttons_d;
    logic [7:0]        pressed_q, pressed_d;
    logic              latch_q, latch_d;
    logic              pulse_q, pulse_d;
    logic              valid_q, valid_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              sample_s;

    assign cnt_inc_s = cnt_q + 1'b1;
    // Pad data is active-low, so a released or unplugged pad reads as 0.
    assign sample_s  = ~sync2_q;

    assign bus.ctrl_latch = latch_q;
    assign bus.ctrl_pulse = pulse_q;
    assign bus.buttons    = buttons_q;
    assign bus.pressed    = pressed_q;
    assign bus.valid      = valid_q;

    // State, counters, synchroniser and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            poll_q    <= '0;
            shift_q   <= 8'h00;
            buttons_q <= 8'h00;
            pressed_q <= 8'h00;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            poll_q    <= poll_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            valid_q   <= valid_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    // Two-flop synchroniser and the free-running poll counter gated by en.
    always_comb begin
        sync1_d = bus.ctrl_data;
        sync2_d = sync1_q;
        if (bus.en) begin
            poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
        end else begin
            poll_d = poll_q;
        end
    end

    // Frame sequencer; pin outputs are computed one cycle ahead so they leave a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        pressed_d = 8'h00;
        latch_d   = 1'b0;
        pulse_d   = 1'b0;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && (poll_q == '0)) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    latch_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_inc_s;
                    latch_d = 1'b1;
                end
            end
            SHIFT: begin
                // Sample at the end of the last low cycle, after the pad output has settled.
                if (cnt_q == HALF_LAST) begin
                    shift_d = {shift_q[6:0], sample_s};
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d   = DONE;
                        buttons_d = shift_q;
                        pressed_d = shift_q & ~buttons_q;
                        valid_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d   = cnt_inc_s;
                    pulse_d = (cnt_inc_s >= HALF);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_controller_reader.sv
// Self-checking bench for controller_reader: pad model, frame-timeline reference
// model compared every cycle, plus hand-computed frame expectations.
module tb_controller_reader;
    localparam int CLK_DIV = 4;
    localparam int POLL    = 100;
    localparam int FRAME   = 18 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controller_reader_if bus();

    controller_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] pad_btn = 8'h00;
    logic       pad_off = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad: snapshots buttons on latch rise, advances one bit per pulse rise.
    int pidx = 8;
    logic [7:0] psnap = 8'h00;
    logic p_prev_latch = 1'b0, p_prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (bus.ctrl_latch === 1'b1 && !p_prev_latch) begin
            psnap = pad_btn;
            pidx  = 0;
        end else if (bus.ctrl_pulse === 1'b1 && !p_prev_pulse && pidx < 8) begin
            pidx++;
        end
        p_prev_latch  = (bus.ctrl_latch === 1'b1);
        p_prev_pulse  = (bus.ctrl_pulse === 1'b1);
        bus.ctrl_data = (pad_off || pidx >= 8) ? 1'b1 : ~psnap[7 - pidx];
    end

    logic cap_rst, cap_en;
    logic cap_ok = 1'b0;
    always @(posedge clk) begin
        cap_rst <= rst;
        cap_en  <= bus.en;
        cap_ok  <= 1'b1;
    end

    // Reference model: a frame is a 73-cycle timeline indexed by age since latch rise.
    int   poll = 0;
    int   age = 0;
    bit   active = 1'b0;
    logic [7:0] snap = 8'h00;
    logic [7:0] m_buttons = 8'h00;
    logic [7:0] e_pressed;
    logic e_latch, e_pulse, e_valid;
    always @(negedge clk) begin
        if (cap_ok) begin
            if (cap_rst) begin
                poll = 0; active = 1'b0; age = 0; m_buttons = 8'h00;
            end else begin
                if (active) begin
                    if (age == FRAME) active = 1'b0;
                    else age++;
                end else if (cap_en && poll == 0) begin
                    active = 1'b1;
                    age    = 0;
                    snap   = pad_off ? 8'h00 : pad_btn;
                end
                if (cap_en) poll = (poll + 1) % POLL;
            end
            e_latch   = active && (age < 2 * CLK_DIV);
            e_pulse   = active && (age >= 2 * CLK_DIV) && (age < FRAME) &&
                        (((age - 2 * CLK_DIV) % (2 * CLK_DIV)) >= CLK_DIV);
            e_valid   = active && (age == FRAME);
            e_pressed = 8'h00;
            if (e_valid) begin
                e_pressed = snap & ~m_buttons;
                m_buttons = snap;
            end
            chk("model_latch",   bus.ctrl_latch, e_latch);
            chk("model_pulse",   bus.ctrl_pulse, e_pulse);
            chk("model_valid",   bus.valid,      e_valid);
            chk("model_buttons", bus.buttons,    m_buttons);
            chk("model_pressed", bus.pressed,    e_pressed);
        end
    end

    // Literal timing monitor: latch width, pulse widths/count, latch-to-valid distance.
    int cyc = 0, last_rise = 0, latch_len = 0, pulse_len = 0, pulses = 0;
    int rise_q[$];
    bit m_prev_latch = 1'b0, m_prev_pulse = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (cap_ok && !cap_rst) begin
            if (bus.ctrl_latch && !m_prev_latch) begin
                last_rise = cyc; latch_len = 0; pulses = 0;
                rise_q.push_back(cyc);
            end
            if (bus.ctrl_latch) latch_len++;
            if (!bus.ctrl_latch && m_prev_latch) chk("latch_high_cycles", latch_len, 8);
            if (bus.ctrl_pulse && !m_prev_pulse) begin pulses++; pulse_len = 0; end
            if (bus.ctrl_pulse) pulse_len++;
            if (!bus.ctrl_pulse && m_prev_pulse) chk("pulse_high_cycles", pulse_len, 4);
            if (bus.ctrl_latch && bus.ctrl_pulse) chk("latch_pulse_overlap", 1, 0);
            if (bus.valid) begin
                chk("pulses_per_frame", pulses, 8);
                chk("latch_to_valid", cyc - last_rise, 72);
            end
        end else begin
            latch_len = 0; pulse_len = 0; pulses = 0;
        end
        m_prev_latch = (bus.ctrl_latch === 1'b1);
        m_prev_pulse = (bus.ctrl_pulse === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_valid(output logic [7:0] b, output logic [7:0] p);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.valid !== 1'b1 && n < 400);
        chk("valid_seen", bus.valid, 1'b1);
        b = bus.buttons;
        p = bus.pressed;
        @(posedge clk); #1;
    endtask

    logic [7:0] b, p;
    initial begin
        bus.en  = 1'b1;
        pad_btn = 8'h11;
        step(1);
        chk("rst_latch",   bus.ctrl_latch, 1'b0);
        chk("rst_pulse",   bus.ctrl_pulse, 1'b0);
        chk("rst_valid",   bus.valid,      1'b0);
        chk("rst_buttons", bus.buttons,    8'h00);
        chk("rst_pressed", bus.pressed,    8'h00);
        step(2);
        rst = 1'b0;
        step(1);
        chk("latch_first_edge", bus.ctrl_latch, 1'b1);

        wait_valid(b, p);
        chk("f1_buttons", b, 8'h11); chk("f1_pressed", p, 8'h11);
        wait_valid(b, p);
        chk("f2_buttons", b, 8'h11); chk("f2_pressed", p, 8'h00);
        pad_btn = 8'h80;
        wait_valid(b, p);
        chk("f3_buttons", b, 8'h80); chk("f3_pressed", p, 8'h80);
        pad_btn = 8'h84;
        wait_valid(b, p);
        chk("f4_buttons", b, 8'h84); chk("f4_pressed", p, 8'h04);
        pad_btn = 8'h00;
        wait_valid(b, p);
        chk("f5_buttons", b, 8'h00); chk("f5_pressed", p, 8'h00);
        for (int i = 1; i < 5; i++) chk("frame_spacing", rise_q[i] - rise_q[i-1], 100);

        bus.en = 1'b0;
        step(50);
        bus.en = 1'b1;
        wait_valid(b, p);
        chk("en_gap_spacing", rise_q[5] - rise_q[4], 150);

        pad_btn = 8'h5A;
        begin
            int n = 0;
            while (bus.ctrl_latch !== 1'b1 && n < 300) begin step(1); n++; end
            chk("latch_seen", bus.ctrl_latch, 1'b1);
        end
        step(42);
        rst = 1'b1;
        step(1);
        chk("midrst_latch",   bus.ctrl_latch, 1'b0);
        chk("midrst_pulse",   bus.ctrl_pulse, 1'b0);
        chk("midrst_valid",   bus.valid,      1'b0);
        chk("midrst_buttons", bus.buttons,    8'h00);
        step(1);
        rst = 1'b0;
        wait_valid(b, p);
        chk("fresh_buttons", b, 8'h5A); chk("fresh_pressed", p, 8'h5A);

        pad_off = 1'b1;
        pad_btn = 8'hFF;
        wait_valid(b, p);
        chk("off_buttons", b, 8'h00); chk("off_pressed", p, 8'h00);
        wait_valid(b, p);
        chk("off2_buttons", b, 8'h00); chk("off2_pressed", p, 8'h00);

        for (int i = 0; i < 30; i++) begin
            pad_btn = 8'($urandom);
            pad_off = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) begin
                step($urandom_range(1, 60));
                bus.en = 1'b0;
                step($urandom_range(1, 60));
                bus.en = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                step($urandom_range(1, 80));
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            wait_valid(b, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
